// File: rtl/reg_bank_pc.sv
// reg_bank_pc
//   Register bank for the bus-based processor datapath: NREGS registers of
//   WIDTH bits (one of them, PC_IDX, is the program counter) plus an
//   instruction register of IWIDTH bits. Everything is written from the
//   shared bus Din and can be frozen globally with Stall.
//
// Ports
//   Clock   rising-edge clock
//   Resetn  asynchronous active-low reset
//   Din     shared bus data
//   Rin     write enables, bit i loads register i (multi-hot allowed)
//   IRin    load IR from the low IWIDTH bits of Din
//   Prox    advance PC by PC_STEP
//   Clear   clear PC to zero
//   Stall   hold every register, IR and PcWrap
//   RdSel   read index (indices >= NREGS read as zero)
//   RdData  contents of register RdSel (combinational)
//   PC      current program counter
//   IR      current instruction register
//   PcWrap  sticky flag, set when a PC increment carries out of WIDTH bits
module reg_bank_pc #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int PC_IDX  = 7,
  parameter int PC_STEP = 1,
  parameter int IWIDTH  = 10,
  parameter int RST_GP  = 2
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [WIDTH-1:0]         Din,
  input  logic [NREGS-1:0]         Rin,
  input  logic                     IRin,
  input  logic                     Prox,
  input  logic                     Clear,
  input  logic                     Stall,
  input  logic [$clog2(NREGS)-1:0] RdSel,
  output logic [WIDTH-1:0]         RdData,
  output logic [WIDTH-1:0]         PC,
  output logic [IWIDTH-1:0]        IR,
  output logic                     PcWrap
);

  localparam int              SELW    = $clog2(NREGS);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_GP);

  logic [WIDTH-1:0]  regs [NREGS];
  logic [IWIDTH-1:0] ir_q;
  logic              pc_wrap;
  logic [WIDTH:0]    pc_sum;

  // One extra bit on the sum so the carry out becomes the wrap indication.
  assign pc_sum = {1'b0, regs[PC_IDX]} + (WIDTH+1)'(PC_STEP);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == PC_IDX) ? '0 : RST_VAL;
      end
      ir_q    <= '0;
      pc_wrap <= 1'b0;
    end else if (!Stall) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i != PC_IDX && Rin[i]) begin
          regs[i] <= Din;
        end
      end
      // PC: bus load beats increment, increment beats clear. Only an applied
      // clear resets the wrap flag; a bus load leaves it untouched.
      if (Rin[PC_IDX]) begin
        regs[PC_IDX] <= Din;
      end else if (Prox) begin
        regs[PC_IDX] <= pc_sum[WIDTH-1:0];
        if (pc_sum[WIDTH]) begin
          pc_wrap <= 1'b1;
        end
      end else if (Clear) begin
        regs[PC_IDX] <= '0;
        pc_wrap      <= 1'b0;
      end
      if (IRin) begin
        ir_q <= Din[IWIDTH-1:0];
      end
    end
  end

  // Decoded read so that indices beyond the populated bank return zero.
  always_comb begin
    RdData = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RdSel == SELW'(i)) begin
        RdData = regs[i];
      end
    end
  end

  assign PC     = regs[PC_IDX];
  assign IR     = ir_q;
  assign PcWrap = pc_wrap;

endmodule

// File: tb/tb_reg_bank_pc.sv
// tb_reg_bank_pc
//   Scoreboard bench for reg_bank_pc. The driver pushes the expected visible
//   state into a queue each cycle; a monitor on the falling edge pops and
//   compares against the DUT outputs.
module tb_reg_bank_pc;

  localparam int WIDTH   = 16;
  localparam int NREGS   = 6;
  localparam int PC_IDX  = 5;
  localparam int PC_STEP = 2;
  localparam int IWIDTH  = 10;
  localparam int RST_GP  = 2;
  localparam int SELW    = 3;

  typedef struct {
    logic [WIDTH-1:0]  pc;
    logic [IWIDTH-1:0] ir;
    logic              wrap;
    logic [SELW-1:0]   sel;
    logic [WIDTH-1:0]  rd;
  } expect_t;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic [WIDTH-1:0]  Din;
  logic [NREGS-1:0]  Rin;
  logic              IRin, Prox, Clear, Stall;
  logic [SELW-1:0]   RdSel;
  logic [WIDTH-1:0]  RdData, PC;
  logic [IWIDTH-1:0] IR;
  logic              PcWrap;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  longint modelRegs [NREGS];
  longint modelIr;
  bit     modelWrap;

  expect_t scoreQ [$];

  reg_bank_pc #(
    .WIDTH(WIDTH), .NREGS(NREGS), .PC_IDX(PC_IDX),
    .PC_STEP(PC_STEP), .IWIDTH(IWIDTH), .RST_GP(RST_GP)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Din(Din), .Rin(Rin), .IRin(IRin),
    .Prox(Prox), .Clear(Clear), .Stall(Stall), .RdSel(RdSel),
    .RdData(RdData), .PC(PC), .IR(IR), .PcWrap(PcWrap)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NREGS; i++) modelRegs[i] = (i == PC_IDX) ? 0 : (RST_GP % (1 << WIDTH));
    modelIr   = 0;
    modelWrap = 0;
  endfunction

  function automatic longint modelRead(input int sel);
    return (sel < NREGS) ? modelRegs[sel] : 0;
  endfunction

  // One clock edge of behaviour from the written rules.
  function automatic void modelEdge(input longint din, input logic [NREGS-1:0] rin,
                                    input bit irin, input bit prox, input bit clear,
                                    input bit stall);
    longint sum;
    if (stall) return;
    for (int i = 0; i < NREGS; i++)
      if (i != PC_IDX && rin[i]) modelRegs[i] = din;
    if (rin[PC_IDX]) begin
      modelRegs[PC_IDX] = din;
    end else if (prox) begin
      sum = modelRegs[PC_IDX] + PC_STEP;
      if (sum >= (longint'(1) << WIDTH)) modelWrap = 1;
      modelRegs[PC_IDX] = sum % (longint'(1) << WIDTH);
    end else if (clear) begin
      modelRegs[PC_IDX] = 0;
      modelWrap = 0;
    end
    if (irin) modelIr = din % (1 << IWIDTH);
  endfunction

  // Called just after a rising edge: drives inputs, queues the expected
  // state for the coming falling edge, then advances through one edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] din, input logic [NREGS-1:0] rin,
                               input bit irin, input bit prox, input bit clear,
                               input bit stall, input logic [SELW-1:0] sel);
    expect_t e;
    Din = din; Rin = rin; IRin = irin; Prox = prox; Clear = clear; Stall = stall;
    RdSel = sel;
    e.pc   = WIDTH'(modelRegs[PC_IDX]);
    e.ir   = IWIDTH'(modelIr);
    e.wrap = modelWrap;
    e.sel  = sel;
    e.rd   = WIDTH'(modelRead(int'(sel)));
    scoreQ.push_back(e);
    @(posedge Clock);
    #1;
    modelEdge(din, rin, irin, prox, clear, stall);
  endtask

  task automatic idle(input logic [SELW-1:0] sel);
    applyStimulus('0, '0, 0, 0, 0, 0, sel);
  endtask

  // Mid-cycle asynchronous reset with an immediate check of the outputs.
  task automatic pulseReset();
    #2;
    Resetn = 1'b0;
    #1;
    modelReset();
    checkOutput("reset PC", PC, 0);
    checkOutput("reset IR", IR, 0);
    checkOutput("reset PcWrap", PcWrap, 0);
    Resetn = 1'b1;
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge Clock) begin
    expect_t e;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput("PC", PC, e.pc);
      checkOutput("IR", IR, e.ir);
      checkOutput("PcWrap", PcWrap, e.wrap);
      checkOutput($sformatf("RdData[%0d]", e.sel), RdData, e.rd);
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    logic [NREGS-1:0] r;
    Resetn = 1'b0; Din = '0; Rin = '0; IRin = 0; Prox = 0; Clear = 0; Stall = 0; RdSel = '0;
    modelReset();
    #12;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    // Reset mid-cycle with a non-zero PC, then read every index.
    applyStimulus(16'h0005, 6'b100000, 0, 0, 0, 0, 3'd0);
    idle(3'd5);
    pulseReset();
    for (int s = 0; s < 8; s++) idle(SELW'(s));

    // Multi-hot load.
    applyStimulus(16'hBEEF, 6'b000011, 0, 0, 0, 0, 3'd0);
    idle(3'd0); idle(3'd1); idle(3'd2); idle(3'd5); idle(3'd7);

    // PC priority: load beats increment beats clear.
    applyStimulus(16'h0010, 6'b100000, 0, 0, 0, 0, 3'd5);
    applyStimulus(16'h0100, 6'b100000, 0, 1, 1, 0, 3'd5);
    applyStimulus(16'h0000, 6'b000000, 0, 1, 1, 0, 3'd5);
    applyStimulus(16'h0000, 6'b000000, 0, 0, 1, 0, 3'd5);

    // Wrap and sticky flag; a load does not clear it, a clear does.
    applyStimulus(16'hFFFF, 6'b100000, 0, 0, 0, 0, 3'd5);
    applyStimulus(16'h0000, 6'b000000, 0, 1, 0, 0, 3'd5);
    applyStimulus(16'h0000, 6'b000000, 0, 1, 0, 0, 3'd5);
    applyStimulus(16'h0040, 6'b100000, 0, 0, 0, 0, 3'd5);
    applyStimulus(16'h0000, 6'b000000, 0, 0, 1, 0, 3'd5);
    applyStimulus(16'hFFFE, 6'b100000, 0, 0, 0, 0, 3'd5);
    applyStimulus(16'h0000, 6'b000000, 0, 1, 0, 0, 3'd5);
    idle(3'd5);

    // Stall freezes everything, release applies the pending load.
    for (int k = 0; k < 3; k++) applyStimulus(16'h1234, 6'b111111, 1, 1, 0, 1, SELW'(k));
    applyStimulus(16'h1234, 6'b111111, 1, 1, 0, 0, 3'd3);
    idle(3'd0); idle(3'd5);

    // IR takes the low bits only; out-of-range reads give zero.
    applyStimulus(16'hFFFF, 6'b000000, 1, 0, 0, 0, 3'd6);
    idle(3'd6); idle(3'd7);

    // Randomised traffic biased towards the top of the PC range.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) pulseReset();
      d = ($urandom_range(0, 2) == 0) ? WIDTH'(16'hFFFF - $urandom_range(0, 4)) : WIDTH'($urandom);
      r = '0;
      for (int b = 0; b < NREGS; b++) r[b] = ($urandom_range(0, 3) == 0);
      applyStimulus(d, r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    SELW'($urandom_range(0, 7)));
    end
    idle(3'd5);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && scoreQ.size() > 0; w++) @(posedge Clock);
    checkOutput("scoreboard drained", scoreQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reg_bank_pc.md
Name: reg_bank_pc

Overview:
Parametrised register bank for the bus-based processor datapath.
- Holds NREGS general/PC registers of WIDTH bits and one instruction register (IR) of IWIDTH bits.
- Register PC_IDX acts as the instruction pointer, with load, step-increment and clear.
- Writes come from the shared bus (Din) under one-hot enables. Reads are by index.
- Adds asynchronous reset, global stall, a parametrised PC step, and a sticky PC wrap flag.

Parameters:
WIDTH, 16, data/register width in bits (>=2)
NREGS, 8, number of bank registers (2..16)
PC_IDX, 7, index of the register acting as program counter (0..NREGS-1)
PC_STEP, 1, increment added to PC on Prox (1..2^WIDTH-1)
IWIDTH, 10, instruction register width (<=WIDTH)
RST_GP, 2, reset value of every non-PC register (truncated to WIDTH)

Ports:
Clock  input  1  rising-edge clock
Resetn  input  1  asynchronous active-low reset
Din  input  WIDTH  shared bus data to be written
Rin  input  NREGS  one-hot-or-multi-hot write enables, bit i targets register i
IRin  input  1  load IR from Din[IWIDTH-1:0]
Prox  input  1  advance PC by PC_STEP
Clear  input  1  clear PC to 0
Stall  input  1  freeze all state (all writes/increments ignored)
RdSel  input  clog2(NREGS)  read index
RdData  output  WIDTH  contents of register RdSel
PC  output  WIDTH  current PC register value
IR  output  IWIDTH  current instruction register value
PcWrap  output  1  sticky: PC increment overflowed past 2^WIDTH-1

Behaviour:
- Resetn low (async, any time, including mid-cycle):
  - PC=0, IR=0, PcWrap=0.
  - All other registers = RST_GP.
  - Takes effect immediately. Outputs valid without a clock edge.
- All state updates occur on the rising Clock edge with Resetn high and Stall low. Stall high: no register, IR or PcWrap changes.
- Non-PC register i: Rin[i]=1 -> R[i]<=Din. Otherwise holds.
- Multi-hot Rin is legal: every selected register loads the same Din in the same cycle.
- PC register, priority highest first (only one action per edge):
  1. Rin[PC_IDX]=1 -> PC<=Din
  2. Prox=1 -> PC<=(PC+PC_STEP) mod 2^WIDTH
  3. Clear=1 -> PC<=0
  4. else hold
- PcWrap:
  - Set on the edge where a Prox increment is applied and PC+PC_STEP >= 2^WIDTH.
  - Cleared only by reset or by a Clear edge that is actually applied (Rin[PC_IDX]=0, Prox=0).
  - A PC load via Rin does not change PcWrap.
  - Set has priority over hold. Set and clear can never coincide, because increment and clear are mutually exclusive.
- IR: IRin=1 -> IR<=Din[IWIDTH-1:0]. Independent of Rin/Prox/Clear.
- RdData is combinational: RdData = R[RdSel]. RdSel >= NREGS -> RdData=0. Reading the PC index returns the PC value.
- PC output is always the PC register value, i.e. registered with no added latency.
- Write-then-read: a value written at edge k is visible on RdData/PC/IR immediately after edge k (1-cycle write latency, 0-cycle read).
- Width rules: arithmetic is unsigned, and the sum is computed in WIDTH+1 bits to detect the carry.

Test Plan:
1. Reset:
   - Assert Resetn=0 mid-cycle with PC=0x0005.
   - -> PC=0, IR=0, PcWrap=0 immediately; RdSel=0..6 all read 0x0002.
2. Load/read with multi-hot enables:
   - Din=0xBEEF, Rin=8'b0000_0011, one edge.
   - -> R0=R1=0xBEEF, R2=0x0002.
   - RdSel=1 -> 0xBEEF; RdSel=7 -> 0x0000.
3. PC priority:
   - PC=0x0010, Rin[7]=1, Din=0x0100, Prox=1, Clear=1 -> PC=0x0100.
   - Next edge Prox=1, Clear=1 -> PC=0x0101.
   - Next edge Clear only -> PC=0.
4. Wrap, with PC_STEP=2:
   - Load PC=0xFFFF, then Prox -> PC=0x0001, PcWrap=1.
   - Further Prox -> PC=0x0003, PcWrap stays 1.
   - Clear -> PC=0, PcWrap=0.
5. Stall:
   - Stall=1 with Rin=all ones, IRin=1, Prox=1, Din=0x1234 for 3 edges -> no state changes.
   - Release Stall -> all load 0x1234 on next edge; PC takes Din since Rin beats Prox; IR=0x234.
6. IR and out-of-range read, with NREGS=6:
   - Din=0xFFFF, IRin=1 -> IR=0x3FF.
   - RdSel=6 or 7 -> RdData=0.
